// File: rtl/fumpy_pkg.sv
// Shared definitions for the result drain path: default sizes, sender state
// encoding and a dimension saturation helper.
package fumpy_pkg;

  localparam int N_DEFAULT      = 4;
  localparam int ADDR_W_DEFAULT = 11;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } sender_state_e;

  // Clamp a requested row/column count to the matrix bound.
  function automatic logic [3:0] sat_dim(input logic [3:0] v, input int unsigned lim);
    logic [4:0] lim5;
    lim5 = 5'(lim);
    return ({1'b0, v} > lim5) ? lim5[3:0] : v;
  endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// 32-bit load/shift register that presents the current MSB byte of a result
// word and flags when the last byte of the word is being presented.
module word_byte_shifter
  import fumpy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // Load a fresh word (byte 0) or move the next byte into the MSB position.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= 32'h0000_0000;
      idx_q  <= 2'd0;
    end else if (load_i) begin
      word_q <= word_i;
      idx_q  <= 2'd0;
    end else if (shift_i) begin
      word_q <= {word_q[23:0], 8'h00};
      idx_q  <= idx_q + 2'd1;
    end else begin
      word_q <= word_q;
      idx_q  <= idx_q;
    end
  end

  assign byte_o = word_q[31:24];
  assign last_o = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/result_uart_sender.sv
// Drains the result matrix row-major from the result RAM and streams every
// 32-bit word over the UART transmitter as four bytes, MSB first.
module result_uart_sender
  import fumpy_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        rows,
  input  logic [3:0]        cols,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        uart_tx_data,
  output logic              uart_send_data,
  input  logic              uart_tx_done
);

  sender_state_e     state_q;
  logic [3:0]        rows_q;
  logic [3:0]        cols_q;
  logic [3:0]        row_q;
  logic [3:0]        col_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              send_q;

  logic [3:0]        adv_row_d;
  logic [3:0]        adv_col_d;
  logic [ADDR_W-1:0] adv_addr_d;
  logic              last_col_s;
  logic              last_word_s;
  logic              last_byte_s;
  logic              load_s;
  logic              shift_s;

  // Next matrix position in row-major order and its RAM address.
  always_comb begin
    adv_row_d  = row_q;
    adv_col_d  = col_q + 4'd1;
    last_col_s = (col_q == (cols_q - 4'd1));
    if (last_col_s) begin
      adv_col_d = 4'd0;
      adv_row_d = row_q + 4'd1;
    end else begin
      adv_col_d = col_q + 4'd1;
      adv_row_d = row_q;
    end
    last_word_s = last_col_s && (row_q == (rows_q - 4'd1));
    adv_addr_d  = ADDR_W'(adv_row_d) * ADDR_W'(N) + ADDR_W'(adv_col_d);
  end

  // RAM data is captured only in LATCH; bytes advance only on an acknowledge
  // that is not for the final byte of the word.
  assign load_s  = (state_q == ST_LATCH);
  assign shift_s = (state_q == ST_WAIT_TX) && uart_tx_done && !last_byte_s;

  word_byte_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_s),
    .shift_i (shift_s),
    .word_i  (rd_data),
    .byte_o  (uart_tx_data),
    .last_o  (last_byte_s)
  );

  // Drain FSM: sequences read, latch, per-byte send/acknowledge and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rows_q    <= 4'd0;
      cols_q    <= 4'd0;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= {ADDR_W{1'b0}};
      send_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      send_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rows_q    <= sat_dim(rows, N);
            cols_q    <= sat_dim(cols, N);
            row_q     <= 4'd0;
            col_q     <= 4'd0;
            rd_addr_q <= {ADDR_W{1'b0}};
            if ((rows == 4'd0) || (cols == 4'd0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          state_q <= ST_SEND;
          send_q  <= 1'b1;
        end
        ST_SEND: begin
          state_q <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (uart_tx_done) begin
            if (!last_byte_s) begin
              state_q <= ST_SEND;
              send_q  <= 1'b1;
            end else if (!last_word_s) begin
              row_q     <= adv_row_d;
              col_q     <= adv_col_d;
              rd_addr_q <= adv_addr_d;
              rd_en_q   <= 1'b1;
              state_q   <= ST_READ;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign uart_send_data = send_q;

endmodule

// File: doc/result_uart_sender.md
# result_uart_sender

Downstream drain stage for the matrix datapath. When the control FSM reports that computation is finished, this block walks the result RAM (matrix C) in row-major order. It reads each 32-bit floating-point result and transmits it over the UART transmitter as four bytes, MSB first, using the existing send/done handshake. It replaces ad-hoc result dumping and owns the UART TX port while active.

## Interface
Parameters:
- N, 4, matrix dimension upper bound; result RAM holds N*N words.
- ADDR_W, 11, result RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse (driven from calc_done) requesting a drain.
- rows  in  4  result row count, sampled on accepted start.
- cols  in  4  result column count, sampled on accepted start.
- busy  out  1  high from accepted start until done pulse (inclusive of last cycle before done).
- done  out  1  one-cycle pulse when the last byte has been acknowledged.
- rd_en  out  1  result RAM read strobe.
- rd_addr  out  ADDR_W  result RAM read address.
- rd_data  in  32  result RAM read data, valid the cycle after rd_en.
- uart_tx_data  out  8  byte to transmit; stable from send pulse until tx_done.
- uart_send_data  out  1  one-cycle request to UART TX.
- uart_tx_done  in  1  one-cycle acknowledge from UART TX that the byte is sent.

## Operation
- States: IDLE, READ, LATCH, SEND, WAIT_TX, DONE.
- IDLE: on start, latch rows/cols (each saturated to N), clear word index and byte index, go to READ. If rows==0 or cols==0, go directly to DONE.
- READ: rd_en=1, rd_addr = row*N + col. Go to LATCH.
- LATCH: capture rd_data into a 32-bit shift register, byte index=0. Go to SEND.
- SEND: uart_send_data=1 for exactly one cycle; uart_tx_data = shift_reg[31:24]. Go to WAIT_TX.
- WAIT_TX: hold uart_tx_data. On uart_tx_done:
  - If byte index<3: shift left by 8, increment byte index, go to SEND.
  - Else, if more words remain: advance col (wrap to 0 and increment row at cols-1), go to READ.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0; return to IDLE.
- Word count is rows*cols (max N*N); row and col counters are 4 bits; address product is computed in ADDR_W bits, with no overflow for N≤16.
- start while busy: ignored. uart_tx_done outside WAIT_TX: ignored. rd_data is sampled only in LATCH.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, uart_tx_data=0, uart_send_data=0; state IDLE; counters 0.
- rst asserted mid-drain: next cycle all outputs are at reset values and no further send pulse occurs. A pending UART byte is abandoned.
- Start sampled in cycle t:
  - rd_en in t+1.
  - rd_data captured at the end of t+2.
  - First uart_send_data in t+3.
- uart_tx_done in cycle k, same word: next uart_send_data in k+1.
- uart_tx_done in cycle k, word boundary: rd_en in k+1, uart_send_data in k+3.
- uart_tx_done in cycle k, final byte: done in k+1.
- Zero-size start in t: done in t+1, no rd_en, no send.
- All outputs are registered.

## Structure
- Shared package fumpy_pkg holds:
  - N, ADDR_W defaults;
  - the sender state enum (typedef enum logic [2:0]);
  - BYTES_PER_WORD=4.
- One sub-module, word_byte_shifter: 32-bit load/shift register exposing the current MSB byte and a last-byte flag. The top level holds the FSM, row/col counters and address generation.

## Test plan
- rows=2, cols=2, RAM words 0x3F800000, 0x40000000, 0x40400000, 0x40800000, tx_done 5 cycles after each send.
  - Expect 16 sends in order 3F 80 00 00 40 00 00 00 40 40 00 00 40 80 00 00.
  - Expect rd_addr 0,1,4,5 (N=4), then one done pulse.
- rows=0, cols=3, start.
  - Expect done exactly one cycle later, no rd_en, no uart_send_data.
- tx_done returned 1 cycle after send (back-to-back).
  - Expect send spacing of 2 cycles within a word and 4 cycles across a word boundary.
- Second start pulse mid-drain, plus spurious uart_tx_done while in READ.
  - Expect both ignored; byte stream identical to the undisturbed run.
- rst asserted for 1 cycle during byte 2 of word 1.
  - Expect all outputs 0 the following cycle and state IDLE.
  - A fresh start restarts from address 0 with byte 0x3F first.
- rows=7, cols=7 with N=4.
  - Expect saturation to 4x4: 64 bytes, last rd_addr 15.
